// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator car blocks (scheduler and controller).
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    TRAVEL   = 2'd2,
    DOOR     = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_N_FLOORS    = 4;
  localparam int DEF_DOOR_CYCLES = 8;

endpackage

// File: rtl/elevator_door_timer.sv
// Door-open hold timer: load/reload restart a DOOR_CYCLES down-count; open while nonzero.
module elevator_door_timer #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic reload,
  output logic open,
  output logic last
);

  localparam int CW = $clog2(DOOR_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load || (reload && cnt != '0)) begin
      cnt <= CW'(DOOR_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign open = (cnt != '0);
  assign last = (cnt == CW'(1));

endmodule

// File: rtl/elevator_scheduler.sv
// Directional SCAN request scheduler for one car; dispatches targets over valid/ready and times the door.
// Optional ELEVATOR_SCHED_STATS_EN adds a saturating served_cnt output counting door entries.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int FW          = $clog2(N_FLOORS),
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] req,
  input  logic [FW-1:0]       curr_floor,
  input  logic                cmd_ready,
  input  logic                arrive,
  output logic                cmd_valid,
  output logic [FW-1:0]       target_floor,
  output logic                dir_up,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
`ifdef ELEVATOR_SCHED_STATS_EN
  ,output logic [15:0]        served_cnt
`endif
);

  // Result packs {found, floor}.
  function automatic logic [FW:0] find_above(input logic [N_FLOORS-1:0] v, input logic [FW-1:0] f);
    find_above = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (v[i] && i > int'(f)) find_above = {1'b1, FW'(i)};
  endfunction

  function automatic logic [FW:0] find_below(input logic [N_FLOORS-1:0] v, input logic [FW-1:0] f);
    find_below = '0;
    for (int i = 0; i < N_FLOORS; i++)
      if (v[i] && i < int'(f)) find_below = {1'b1, FW'(i)};
  endfunction

  state_t              state;
  logic [N_FLOORS-1:0] cur_bit, eff, pend_nxt;
  logic [FW:0]         above, below;
  logic                at_cur, pick_up, pick_down, door_entry, door_reload, door_last;

  assign cur_bit     = N_FLOORS'(1) << curr_floor;
  assign eff         = pending | req;
  assign at_cur      = |(eff & cur_bit);
  assign above       = find_above(eff, curr_floor);
  assign below       = find_below(eff, curr_floor);
  assign pick_up     = above[FW] && (dir_up || !below[FW]);
  assign pick_down   = below[FW] && !pick_up;
  assign door_entry  = (state == IDLE && at_cur) || (state == TRAVEL && arrive);
  assign door_reload = (state == DOOR) && |(req & cur_bit);

  // Clearing on door entry beats a same-cycle request; during DOOR the current floor is not latched.
  always_comb begin
    pend_nxt = pending | req;
    if (door_entry)
      pend_nxt = pend_nxt & ~cur_bit;
    else if (state == DOOR)
      pend_nxt = (pend_nxt & ~cur_bit) | (pending & cur_bit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      cmd_valid    <= 1'b0;
      target_floor <= '0;
      dir_up       <= DIR_UP;
      busy         <= 1'b0;
    end else begin
      pending <= pend_nxt;
      case (state)
        IDLE: begin
          if (at_cur) begin
            state <= DOOR;
            busy  <= 1'b1;
          end else if (pick_up || pick_down) begin
            state        <= DISPATCH;
            cmd_valid    <= 1'b1;
            busy         <= 1'b1;
            target_floor <= pick_up ? above[FW-1:0] : below[FW-1:0];
            dir_up       <= pick_up ? DIR_UP : DIR_DOWN;
          end
        end
        DISPATCH: begin
          if (cmd_ready) begin
            state     <= TRAVEL;
            cmd_valid <= 1'b0;
          end
        end
        TRAVEL: begin
          if (arrive) state <= DOOR;
        end
        DOOR: begin
          if (door_last && !door_reload) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  elevator_door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk   (clk),
    .reset (reset),
    .load  (door_entry),
    .reload(door_reload),
    .open  (door_open),
    .last  (door_last)
  );

`ifdef ELEVATOR_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      served_cnt <= '0;
    else if (door_entry && served_cnt != 16'hFFFF)
      served_cnt <= served_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed vector table, corner-case sequences, random run vs reference model.
module tb_elevator_scheduler;

  localparam int NF = 4;
  localparam int DC = 8;
  localparam int M_IDLE = 0, M_DISP = 1, M_TRAV = 2, M_DOOR = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] req = '0;
  logic [1:0]    curr_floor = '0;
  logic          cmd_ready = 1'b0;
  logic          arrive = 1'b0;
  logic          cmd_valid;
  logic [1:0]    target_floor;
  logic          dir_up;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          busy;
`ifdef ELEVATOR_SCHED_STATS_EN
  logic [15:0]   served_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .N_FLOORS(NF),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .curr_floor  (curr_floor),
    .cmd_ready   (cmd_ready),
    .arrive      (arrive),
    .cmd_valid   (cmd_valid),
    .target_floor(target_floor),
    .dir_up      (dir_up),
    .door_open   (door_open),
    .pending     (pending),
    .busy        (busy)
`ifdef ELEVATOR_SCHED_STATS_EN
    ,.served_cnt (served_cnt)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic [1:0] cf;
    logic       rdy;
    logic       arr;
    logic       cv;
    logic [1:0] tf;
    logic       du;
    logic       dop;
    logic       bz;
    logic [3:0] pd;
  } vec_t;

  vec_t vecs[15];

  // Reference model state
  logic [3:0] m_pend;
  int m_mode, m_tgt, m_dir, m_door, m_srv, car;

  function automatic vec_t mkv(logic [3:0] r, logic [1:0] cf, logic rdy, logic arr,
                               logic cv, logic [1:0] tf, logic du, logic dop, logic bz, logic [3:0] pd);
    vec_t v;
    v.req = r; v.cf = cf; v.rdy = rdy; v.arr = arr;
    v.cv = cv; v.tf = tf; v.du = du; v.dop = dop; v.bz = bz; v.pd = pd;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string p, input int cv, input int tf, input int du,
                         input int dop, input int bz, input int pd);
    check({p, ".cmd_valid"}, int'(cmd_valid), cv);
    check({p, ".target_floor"}, int'(target_floor), tf);
    check({p, ".dir_up"}, int'(dir_up), du);
    check({p, ".door_open"}, int'(door_open), dop);
    check({p, ".busy"}, int'(busy), bz);
    check({p, ".pending"}, int'(pending), pd);
  endtask

  // Apply inputs just after a falling edge; return at the next falling edge.
  task automatic cyc(input logic [3:0] r, input logic [1:0] cf, input logic rdy, input logic arr);
    req = r; curr_floor = cf; cmd_ready = rdy; arrive = arr;
    @(negedge clk);
  endtask

  // Counts door_open samples (including the current one) until it drops; bounded.
  task automatic drain(input logic [1:0] cf, output int n);
    n = 0;
    for (int k = 0; k < 40 && door_open; k++) begin
      n++;
      cyc(4'b0000, cf, 1'b0, 1'b0);
    end
  endtask

  function automatic int nearest(input logic [3:0] v, input int cf, input int up);
    if (up != 0) begin
      for (int f = cf + 1; f < NF; f++) if (v[f]) return f;
    end else begin
      for (int f = cf - 1; f >= 0; f--) if (v[f]) return f;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input int cf, input logic rdy, input logic arr);
    logic [3:0] eff, nxt;
    int up, dn;
    eff = m_pend | r;
    nxt = eff;
    case (m_mode)
      M_IDLE: begin
        up = nearest(eff, cf, 1);
        dn = nearest(eff, cf, 0);
        if (eff[cf]) begin
          m_mode = M_DOOR; m_door = DC; nxt[cf] = 1'b0;
          if (m_srv < 65535) m_srv++;
        end else if (m_dir == 1) begin
          if (up >= 0) begin m_tgt = up; m_mode = M_DISP; end
          else if (dn >= 0) begin m_tgt = dn; m_mode = M_DISP; m_dir = 0; end
        end else begin
          if (dn >= 0) begin m_tgt = dn; m_mode = M_DISP; end
          else if (up >= 0) begin m_tgt = up; m_mode = M_DISP; m_dir = 1; end
        end
      end
      M_DISP: if (rdy) m_mode = M_TRAV;
      M_TRAV: if (arr) begin
        m_mode = M_DOOR; m_door = DC; nxt[cf] = 1'b0;
        if (m_srv < 65535) m_srv++;
      end
      default: begin
        if (r[cf]) begin
          m_door = DC;
          nxt[cf] = m_pend[cf];
        end else begin
          m_door--;
          if (m_door == 0) m_mode = M_IDLE;
        end
      end
    endcase
    m_pend = nxt;
  endtask

  task automatic chk_model(input string p);
    chk_all(p, int'(m_mode == M_DISP), m_tgt, m_dir, int'(m_door > 0),
            int'(m_mode != M_IDLE), int'(m_pend));
`ifdef ELEVATOR_SCHED_STATS_EN
    check({p, ".served_cnt"}, int'(served_cnt), m_srv);
`endif
  endtask

  initial begin
    int n;
    logic [3:0] r;
    logic rdy, arr;

    // Floor 2 request from floor 0: dispatch, 3 stalled cycles, travel, arrive, 8-cycle door.
    vecs[0] = mkv(4'b0100, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0100);
    for (int i = 1; i <= 3; i++)
      vecs[i] = mkv(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0100);
    vecs[4] = mkv(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0100);
    vecs[5] = mkv(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0100);
    vecs[6] = mkv(4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0000);
    for (int i = 7; i <= 13; i++)
      vecs[i] = mkv(4'b0000, 2'd2, 1'b0, (i == 8), 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0000);
    vecs[14] = mkv(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);

    repeat (2) @(negedge clk);
    chk_all("in_reset", 0, 0, 1, 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(4'b0000, 2'd0, 1'b0, 1'b0);
      check($sformatf("idle%0d.busy", k), int'(busy), 0);
    end
    chk_all("after_idle", 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].req, vecs[i].cf, vecs[i].rdy, vecs[i].arr);
      chk_all($sformatf("vec%0d", i), vecs[i].cv, vecs[i].tf, vecs[i].du,
              vecs[i].dop, vecs[i].bz, vecs[i].pd);
    end

    // Scan keeps going up to 3, then reverses down to 0.
    cyc(4'b1001, 2'd1, 1'b0, 1'b0);
    chk_all("scan_up", 1, 3, 1, 0, 1, 9);
    cyc(4'b0000, 2'd1, 1'b1, 1'b0);
    check("scan_travel.cmd_valid", int'(cmd_valid), 0);
    cyc(4'b0000, 2'd3, 1'b0, 1'b1);
    check("scan_arrive.door_open", int'(door_open), 1);
    check("scan_arrive.pending", int'(pending), 1);
    drain(2'd3, n);
    check("scan_door3.cycles", n, DC);
    cyc(4'b0000, 2'd3, 1'b0, 1'b0);
    chk_all("scan_rev", 1, 0, 0, 0, 1, 1);
    cyc(4'b0000, 2'd3, 1'b1, 1'b0);
    cyc(4'b0000, 2'd0, 1'b0, 1'b1);
    drain(2'd0, n);
    check("scan_door0.cycles", n, DC);

    // Request at the current floor opens the door directly; a re-pulse extends it.
    cyc(4'b0100, 2'd2, 1'b0, 1'b0);
    chk_all("here", 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(4'b0000, 2'd2, 1'b0, 1'b0);
    check("here_c5.door_open", int'(door_open), 1);
    cyc(4'b0100, 2'd2, 1'b0, 1'b0);
    check("reload.pending", int'(pending), 0);
    drain(2'd2, n);
    check("reload.cycles", n, DC);
    check("reload_end.cmd_valid", int'(cmd_valid), 0);
    check("reload_end.busy", int'(busy), 0);

    // Asynchronous reset while travelling.
    cyc(4'b1010, 2'd2, 1'b0, 1'b0);
    chk_all("down_pick", 1, 1, 0, 0, 1, 10);
    cyc(4'b0000, 2'd2, 1'b1, 1'b0);
    check("trav.busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_all("async_rst", 0, 0, 1, 0, 0, 0);
`ifdef ELEVATOR_SCHED_STATS_EN
    check("async_rst.served_cnt", int'(served_cnt), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    cyc(4'b0000, 2'd1, 1'b0, 1'b1);
    check("stray_arrive.door_open", int'(door_open), 0);
    check("stray_arrive.busy", int'(busy), 0);

`ifdef ELEVATOR_SCHED_STATS_EN
    cyc(4'b0100, 2'd2, 1'b0, 1'b0); drain(2'd2, n);
    cyc(4'b0001, 2'd0, 1'b0, 1'b0); drain(2'd0, n);
    cyc(4'b1000, 2'd3, 1'b0, 1'b0); drain(2'd3, n);
    check("served_cnt", int'(served_cnt), 3);
`endif

    // Random traffic against the reference model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_pend = '0; m_mode = M_IDLE; m_tgt = 0; m_dir = 1; m_door = 0; m_srv = 0; car = 0;
    for (int t = 0; t < 3000; t++) begin
      chk_model($sformatf("rnd%0d", t));
      r = '0;
      if ($urandom_range(0, 4) == 0) r[$urandom_range(0, NF - 1)] = 1'b1;
      rdy = 1'($urandom_range(0, 1));
      arr = 1'b0;
      if (m_mode == M_TRAV) begin
        if ($urandom_range(0, 3) == 0) begin
          arr = 1'b1;
          car = m_tgt;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        arr = 1'b1;
      end
      model_step(r, car, rdy, arr);
      cyc(r, 2'(car), rdy, arr);
    end
    chk_model("rnd_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Request scheduler that sits in front of the elevator car's motion datapath. It latches floor requests and picks the next target floor using directional SCAN (keep going the same way while requests remain ahead). It dispatches the target to the motion controller over a valid/ready handshake and times the door-open interval on arrival. One instance serves one car.

Parameters:
N_FLOORS, 4, number of floors; must be ≥2
FW, $clog2(N_FLOORS), floor index width
DOOR_CYCLES, 8, door-open hold time in clk cycles; must be ≥1

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
req  input  N_FLOORS  request bitmap; bit f high for ≥1 cycle requests floor f
curr_floor  input  FW  car's current floor, from motion controller
cmd_ready  input  1  motion controller accepts target this cycle
arrive  input  1  1-cycle pulse: car stopped at dispatched target
cmd_valid  output  1  target_floor valid, held until cmd_ready
target_floor  output  FW  floor to travel to
dir_up  output  1  current scan direction (1 = up, 0 = down)
door_open  output  1  door-open command
pending  output  N_FLOORS  latched unserved requests
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: pending=0, cmd_valid=0, target_floor=0, dir_up=1, door_open=0, busy=0, state=IDLE, door counter=0.
- Request latching: every cycle pending <= pending | req, masked as described below. Reset mid-operation drops all pending requests and returns to IDLE within the same asynchronous event.
- States: IDLE, DISPATCH, TRAVEL, DOOR.
- IDLE, evaluated each cycle in priority order; the decision uses the registered pending value OR'd with the current req:
  - bit at curr_floor set → DOOR next cycle; clear that bit.
  - dir_up=1 and any bit above curr_floor → target = lowest set bit above; go to DISPATCH.
  - else any bit below → target = highest set bit below; dir_up<=0; go to DISPATCH.
  - dir_up=0 uses the mirrored rule: nearest below first, else nearest above and set dir_up<=1.
  - nothing set → stay in IDLE; dir_up holds.
- DISPATCH: cmd_valid=1; target_floor stable. On cmd_valid&&cmd_ready go to TRAVEL; cmd_valid drops next cycle.
- TRAVEL: wait for arrive. On arrive go to DOOR and clear pending[curr_floor]. The target is fixed once dispatched; there are no intermediate stops.
- Stray pulses: arrive in IDLE, DISPATCH or DOOR is ignored. cmd_ready outside DISPATCH is ignored.
- DOOR: door_open=1 for exactly DOOR_CYCLES cycles, then IDLE with door_open=0.
  - req bit at curr_floor during DOOR reloads the counter (door stays open) and is not latched into pending.
- Same-cycle req and clear at curr_floor: clear wins on the DOOR-entry cycle.
- Latency: request at the current floor in IDLE → door_open 1 cycle later. Request elsewhere → cmd_valid 1 cycle later.
- Wrap-around: none. Floors 0 and N_FLOORS-1 are hard ends; with no requests ahead, the scan reverses.

Optional Feature:
ELEVATOR_SCHED_STATS_EN
- Defined: adds output served_cnt[15:0], incremented on each DOOR entry. It saturates at 16'hFFFF and is cleared by reset.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package elevator_pkg:
  - state enum (IDLE/DISPATCH/TRAVEL/DOOR)
  - DIR_UP/DIR_DOWN constants
  - default N_FLOORS/DOOR_CYCLES localparams
  - shared with Elevator_controller.
- Sub-module elevator_door_timer:
  - inputs: load, reload
  - output: open
  - internals: down-counter with DOOR_CYCLES.
- Nearest-floor search stays inline as combinational functions.

Test Plan:
- Reset with req=4'b0000 → all outputs at reset values; IDLE held 10 cycles with busy=0.
- curr_floor=0, req=4'b0100 for 1 cycle → cmd_valid with target_floor=2, dir_up=1. Hold cmd_ready=0 for 3 cycles, then 1 → TRAVEL. Then arrive → door_open for 8 cycles, pending[2]=0.
- curr_floor=1, dir_up=1, pending=4'b1001 → target 3 first. After arrive at 3 with the door cycle done → target 0 and dir_up=0.
- curr_floor=2 in IDLE, req=4'b0100 → door_open next cycle, no cmd_valid. Re-pulse req[2] at door cycle 5 → door stays open 8 more cycles.
- Assert reset during TRAVEL with pending=4'b1010 → pending=0, state IDLE, cmd_valid=0, door_open=0 immediately. A later arrive is ignored.
- With ELEVATOR_SCHED_STATS_EN: serve floors 2, 0, 3 → served_cnt=3. Without it, the port is absent.
